dmem_subsystem: RTL

- Data-memory endpoint directly downstream of the RV32I core's store/load path.
- Consumes the core's write request, address, data and byte mask, and returns load data in the same cycle.
- Serves a word-addressed tightly coupled RAM (TCM) plus a write-only peripheral region.
- Peripheral writes are posted into a FIFO and drained over an APB master port, so the core never stalls.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/dmem_subsystem.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory endpoint: region decode, APB states,
// posted-write FIFO entry layout and status-word bit positions.
package dmem_pkg;

    localparam logic [3:0] TCM_REGION    = 4'h0;
    localparam logic [3:0] PERIPH_REGION = 4'h4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } fifo_entry_t;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVF       = 2;
    localparam int STAT_SLVERR    = 3;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_W   = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is accepted only
// when a pop happens in the same cycle. DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             push_ok,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign push_ok = push && (!full || do_pop);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !do_pop)
                count <= count + 1'b1;
            else if (!push_ok && do_pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dmem_subsystem.sv
// Data-memory endpoint: byte-masked TCM with combinational read, plus a posted
// peripheral-write FIFO drained by an APB master so the core never stalls.
module dmem_subsystem
    import dmem_pkg::*;
#(
    parameter int         TCM_AW        = 10,
    parameter int         FIFO_DEPTH    = 4,
    parameter logic [3:0] PERIPH_NIBBLE = PERIPH_REGION,
    parameter logic [3:0] TCM_NIBBLE    = TCM_REGION
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        dmwr_req_in,
    input  logic [31:0] dmaddr_in,
    input  logic [31:0] dmdata_in,
    input  logic [3:0]  dmwr_mask_in,
    output logic [31:0] dmdata_out,
    output logic [31:0] paddr_out,
    output logic        psel_out,
    output logic        penable_out,
    output logic        pwrite_out,
    output logic [31:0] pwdata_out,
    output logic [3:0]  pstrb_out,
    input  logic        pready_in,
    input  logic        pslverr_in,
    output logic        ovf_out,
    output logic        slverr_out
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              is_tcm;
    logic              is_periph;
    logic [TCM_AW-1:0] tcm_idx;
    logic [31:0]       tcm [1 << TCM_AW];
    logic [31:0]       status;
    logic              unused_addr_lsbs;

    assign is_tcm           = (dmaddr_in[31:28] == TCM_NIBBLE);
    assign is_periph        = (dmaddr_in[31:28] == PERIPH_NIBBLE);
    assign tcm_idx          = dmaddr_in[TCM_AW+1:2];
    assign unused_addr_lsbs = ^dmaddr_in[1:0];

    always_ff @(posedge clk_in) begin
        if (dmwr_req_in && is_tcm) begin
            for (int b = 0; b < 4; b++) begin
                if (dmwr_mask_in[b]) tcm[tcm_idx][8*b +: 8] <= dmdata_in[8*b +: 8];
            end
        end
    end

    fifo_entry_t push_entry;
    fifo_entry_t head;
    logic        periph_push;
    logic        fifo_pop;
    logic        push_ok;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;
    apb_state_t  state;

    assign periph_push = dmwr_req_in && is_periph;
    assign fifo_pop    = (state == ACCESS) && pready_in;
    assign push_entry  = '{addr: {dmaddr_in[31:2], 2'b00}, data: dmdata_in, strb: dmwr_mask_in};

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (periph_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head),
        .push_ok   (push_ok),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            psel_out    <= 1'b0;
            penable_out <= 1'b0;
            pwrite_out  <= 1'b0;
            ovf_out     <= 1'b0;
            slverr_out  <= 1'b0;
        end else begin
            if (periph_push && !push_ok) ovf_out <= 1'b1;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state      <= SETUP;
                        psel_out   <= 1'b1;
                        pwrite_out <= 1'b1;
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    penable_out <= 1'b1;
                end
                ACCESS: begin
                    if (pready_in) begin
                        slverr_out  <= slverr_out | pslverr_in;
                        penable_out <= 1'b0;
                        // A push landing in the pop cycle keeps the bus busy.
                        if (fifo_count > CW'(1) || push_ok) begin
                            state <= SETUP;
                        end else begin
                            state      <= IDLE;
                            psel_out   <= 1'b0;
                            pwrite_out <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The head only moves on a pop, so it is stable across SETUP and ACCESS.
    assign paddr_out  = psel_out ? head.addr : '0;
    assign pwdata_out = psel_out ? head.data : '0;
    assign pstrb_out  = psel_out ? head.strb : '0;

    always_comb begin
        status                                    = '0;
        status[STAT_EMPTY]                        = fifo_empty;
        status[STAT_FULL]                         = fifo_full;
        status[STAT_OVF]                          = ovf_out;
        status[STAT_SLVERR]                       = slverr_out;
        status[STAT_COUNT_LSB +: STAT_COUNT_W]    = STAT_COUNT_W'(fifo_count);
    end

    always_comb begin
        dmdata_out = '0;
        if (is_tcm)
            dmdata_out = tcm[tcm_idx];
        else if (is_periph)
            dmdata_out = status;
    end

endmodule
